// File: rtl/uart_tx_serializer.sv
// ---------------------------------------------------------------------------
// uart_tx_serializer
//   Byte-to-serial UART transmit stage. Accepts one word per valid/ready
//   handshake and emits an asynchronous frame: start bit, data LSB first,
//   optional parity bit, then 1 or 2 stop bits. Bit timing comes from an
//   internal baud divider running on the system clock.
//
// Ports:
//   CpSl_Clk_i      in   1  system clock, single clock of the block
//   CpSl_Rst_iN     in   1  synchronous active-low reset
//   CpSv_TxData_i   in   8  data word, bits [PrSv_DataBits_c-1:0] used
//   CpSl_TxValid_i  in   1  upstream word valid
//   CpSl_TxReady_o  out  1  block can accept a word (IDLE only)
//   CpSl_TxBusy_o   out  1  frame on the line
//   CpSl_TxDone_o   out  1  pulse in the final cycle of the last stop bit
//   CpSl_Txdata_o   out  1  serial line, idles high
// ---------------------------------------------------------------------------
module uart_tx_serializer #(
    parameter int unsigned PrSv_BaudDiv_c   = 868,
    parameter int unsigned PrSv_DataBits_c  = 8,
    parameter int unsigned PrSl_ParityEn_c  = 0,
    parameter int unsigned PrSl_ParityOdd_c = 0,
    parameter int unsigned PrSv_StopBits_c  = 1
) (
    input  logic       CpSl_Clk_i,
    input  logic       CpSl_Rst_iN,
    input  logic [7:0] CpSv_TxData_i,
    input  logic       CpSl_TxValid_i,
    output logic       CpSl_TxReady_o,
    output logic       CpSl_TxBusy_o,
    output logic       CpSl_TxDone_o,
    output logic       CpSl_Txdata_o
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_e;

    localparam logic [15:0] BaudLast_c    = 16'(PrSv_BaudDiv_c - 1);
    // Done is registered, so it is raised one cycle ahead of the last cycle.
    localparam logic [15:0] BaudPreLast_c = 16'(PrSv_BaudDiv_c - 2);
    localparam logic [2:0]  LastBit_c     = 3'(PrSv_DataBits_c - 1);
    localparam logic        LastStop_c    = 1'(PrSv_StopBits_c - 1);
    localparam logic [7:0]  DataMask_c    = 8'((2 ** PrSv_DataBits_c) - 1);
    localparam logic        ParityEn_c    = 1'(PrSl_ParityEn_c);
    localparam logic        ParityOdd_c   = 1'(PrSl_ParityOdd_c);

    // Even parity of a word (unused upper bits must already be masked off).
    function automatic logic even_parity_f(input logic [7:0] word);
        return ^word;
    endfunction

    state_e      state_q,    state_d;
    logic [15:0] baud_cnt_q, baud_cnt_d;
    logic [2:0]  bit_cnt_q,  bit_cnt_d;
    logic        stop_cnt_q, stop_cnt_d;
    logic [7:0]  shift_q,    shift_d;
    logic        parity_q,   parity_d;
    logic        line_q,     line_d;
    logic        ready_q,    ready_d;
    logic        busy_q,     busy_d;
    logic        done_q,     done_d;

    logic        accept_s;
    logic        baud_wrap_s;
    logic [7:0]  masked_s;

    // Handshake and baud-wrap decode.
    always_comb begin
        // ready_q is only ever high in IDLE, so it alone qualifies the accept.
        accept_s    = ready_q & CpSl_TxValid_i;
        baud_wrap_s = (baud_cnt_q == BaudLast_c);
        masked_s    = CpSv_TxData_i & DataMask_c;
    end

    // Next-state logic for the frame sequencer and its counters.
    always_comb begin
        state_d    = state_q;
        baud_cnt_d = baud_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        shift_d    = shift_q;
        parity_d   = parity_q;
        case (state_q)
            ST_IDLE: begin
                baud_cnt_d = 16'd0;
                bit_cnt_d  = 3'd0;
                stop_cnt_d = 1'b0;
                if (accept_s) begin
                    state_d  = ST_START;
                    shift_d  = masked_s;
                    parity_d = even_parity_f(masked_s) ^ ParityOdd_c;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_START: begin
                if (baud_wrap_s) begin
                    baud_cnt_d = 16'd0;
                    state_d    = ST_DATA;
                end else begin
                    baud_cnt_d = baud_cnt_q + 16'd1;
                end
            end
            ST_DATA: begin
                if (baud_wrap_s) begin
                    baud_cnt_d = 16'd0;
                    // Line always shows shift[0]; shifting exposes the next bit.
                    shift_d    = {1'b0, shift_q[7:1]};
                    if (bit_cnt_q == LastBit_c) begin
                        bit_cnt_d = 3'd0;
                        if (ParityEn_c) begin
                            state_d = ST_PARITY;
                        end else begin
                            state_d = ST_STOP;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + 16'd1;
                end
            end
            ST_PARITY: begin
                if (baud_wrap_s) begin
                    baud_cnt_d = 16'd0;
                    state_d    = ST_STOP;
                end else begin
                    baud_cnt_d = baud_cnt_q + 16'd1;
                end
            end
            ST_STOP: begin
                if (baud_wrap_s) begin
                    baud_cnt_d = 16'd0;
                    if (stop_cnt_q == LastStop_c) begin
                        stop_cnt_d = 1'b0;
                        state_d    = ST_IDLE;
                    end else begin
                        stop_cnt_d = stop_cnt_q + 1'b1;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + 16'd1;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                baud_cnt_d = 16'd0;
                bit_cnt_d  = 3'd0;
                stop_cnt_d = 1'b0;
                shift_d    = 8'd0;
                parity_d   = 1'b0;
            end
        endcase
    end

    // Output next values, derived from the next state so outputs stay registered.
    always_comb begin
        case (state_d)
            ST_IDLE:   line_d = 1'b1;
            ST_START:  line_d = 1'b0;
            ST_DATA:   line_d = shift_d[0];
            ST_PARITY: line_d = parity_d;
            ST_STOP:   line_d = 1'b1;
            default:   line_d = 1'b1;
        endcase
        ready_d = (state_d == ST_IDLE);
        busy_d  = (state_d != ST_IDLE);
        done_d  = (state_q == ST_STOP) && (stop_cnt_q == LastStop_c) &&
                  (baud_cnt_q == BaudPreLast_c);
    end

    // State, counter and output registers with synchronous active-low reset.
    always_ff @(posedge CpSl_Clk_i) begin
        if (!CpSl_Rst_iN) begin
            state_q    <= ST_IDLE;
            baud_cnt_q <= 16'd0;
            bit_cnt_q  <= 3'd0;
            stop_cnt_q <= 1'b0;
            shift_q    <= 8'd0;
            parity_q   <= 1'b0;
            line_q     <= 1'b1;
            ready_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_cnt_q <= baud_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            shift_q    <= shift_d;
            parity_q   <= parity_d;
            line_q     <= line_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign CpSl_Txdata_o  = line_q;
    assign CpSl_TxReady_o = ready_q;
    assign CpSl_TxBusy_o  = busy_q;
    assign CpSl_TxDone_o  = done_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_serializer
//   Four instances with different frame formats share clock and reset:
//     0: div 4, 8N1   1: div 4, 8O1   2: div 4, 8E1   3: div 868, 7E2
//   Expected line/busy/ready/done per cycle come from a bit-list model.
//   Vectors are {line, busy, ready, done}.
// ---------------------------------------------------------------------------
module tb_uart_tx_serializer;

    localparam int NI = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] data_a  [NI];
    logic       valid_a [NI];
    logic       line_a  [NI];
    logic       ready_a [NI];
    logic       busy_a  [NI];
    logic       done_a  [NI];

    int div_t   [NI] = '{4, 4, 4, 868};
    int bits_t  [NI] = '{8, 8, 8, 7};
    int pen_t   [NI] = '{0, 1, 1, 1};
    int podd_t  [NI] = '{0, 1, 0, 0};
    int nstop_t [NI] = '{1, 1, 1, 2};

    int n_cmp = 0;
    int n_bad = 0;

    logic [3:0] obs_q [$];
    logic [3:0] exp_q [$];

    always #5 clk = ~clk;

    uart_tx_serializer #(.PrSv_BaudDiv_c(4), .PrSv_DataBits_c(8), .PrSl_ParityEn_c(0),
                         .PrSl_ParityOdd_c(0), .PrSv_StopBits_c(1)) u_8n1 (
        .CpSl_Clk_i(clk), .CpSl_Rst_iN(rst_n), .CpSv_TxData_i(data_a[0]),
        .CpSl_TxValid_i(valid_a[0]), .CpSl_TxReady_o(ready_a[0]), .CpSl_TxBusy_o(busy_a[0]),
        .CpSl_TxDone_o(done_a[0]), .CpSl_Txdata_o(line_a[0]));

    uart_tx_serializer #(.PrSv_BaudDiv_c(4), .PrSv_DataBits_c(8), .PrSl_ParityEn_c(1),
                         .PrSl_ParityOdd_c(1), .PrSv_StopBits_c(1)) u_8o1 (
        .CpSl_Clk_i(clk), .CpSl_Rst_iN(rst_n), .CpSv_TxData_i(data_a[1]),
        .CpSl_TxValid_i(valid_a[1]), .CpSl_TxReady_o(ready_a[1]), .CpSl_TxBusy_o(busy_a[1]),
        .CpSl_TxDone_o(done_a[1]), .CpSl_Txdata_o(line_a[1]));

    uart_tx_serializer #(.PrSv_BaudDiv_c(4), .PrSv_DataBits_c(8), .PrSl_ParityEn_c(1),
                         .PrSl_ParityOdd_c(0), .PrSv_StopBits_c(1)) u_8e1 (
        .CpSl_Clk_i(clk), .CpSl_Rst_iN(rst_n), .CpSv_TxData_i(data_a[2]),
        .CpSl_TxValid_i(valid_a[2]), .CpSl_TxReady_o(ready_a[2]), .CpSl_TxBusy_o(busy_a[2]),
        .CpSl_TxDone_o(done_a[2]), .CpSl_Txdata_o(line_a[2]));

    uart_tx_serializer #(.PrSv_BaudDiv_c(868), .PrSv_DataBits_c(7), .PrSl_ParityEn_c(1),
                         .PrSl_ParityOdd_c(0), .PrSv_StopBits_c(2)) u_7e2 (
        .CpSl_Clk_i(clk), .CpSl_Rst_iN(rst_n), .CpSv_TxData_i(data_a[3]),
        .CpSl_TxValid_i(valid_a[3]), .CpSl_TxReady_o(ready_a[3]), .CpSl_TxBusy_o(busy_a[3]),
        .CpSl_TxDone_o(done_a[3]), .CpSl_Txdata_o(line_a[3]));

    // Reference model: list of frame bits, each held div cycles, done in the last cycle.
    task automatic add_frame(input int idx, input logic [7:0] word);
        logic bl [$];
        int   ones;
        int   total;
        int   k;
        ones = 0;
        bl.push_back(1'b0);
        for (int i = 0; i < bits_t[idx]; i++) begin
            bl.push_back(word[i]);
            ones += int'(word[i]);
        end
        if (pen_t[idx] != 0) begin
            if (podd_t[idx] != 0) bl.push_back((ones % 2) == 0);
            else                  bl.push_back((ones % 2) == 1);
        end
        for (int s = 0; s < nstop_t[idx]; s++) bl.push_back(1'b1);
        total = bl.size() * div_t[idx];
        k = 0;
        foreach (bl[j]) begin
            for (int c = 0; c < div_t[idx]; c++) begin
                k++;
                exp_q.push_back({bl[j], 1'b1, 1'b0, k == total});
            end
        end
    endtask

    task automatic add_idle(input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(4'b1010);
    endtask

    task automatic launch(input int idx, input logic [7:0] word);
        @(negedge clk);
        data_a[idx]  = word;
        valid_a[idx] = 1'b1;
    endtask

    // Record n cycles starting at T0+1; optionally pulse valid at cycle index pulse_at.
    task automatic capture(input int idx, input int n, input logic [7:0] post_data,
                           input logic post_valid, input int pulse_at, input logic [7:0] pulse_data);
        obs_q.delete();
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            obs_q.push_back({line_a[idx], busy_a[idx], ready_a[idx], done_a[idx]});
            if (i == 0) begin
                data_a[idx]  = post_data;
                valid_a[idx] = post_valid;
            end
            if (i == pulse_at) begin
                data_a[idx]  = pulse_data;
                valid_a[idx] = 1'b1;
            end else if (i == pulse_at + 1) begin
                valid_a[idx] = 1'b0;
            end
        end
        valid_a[idx] = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < NI; i++) begin
            valid_a[i] = 1'b0;
            data_a[i]  = 8'h00;
        end
        repeat (2) begin
            @(negedge clk);
            for (int i = 0; i < NI; i++) begin
                n_cmp++;
                if ({line_a[i], busy_a[i], ready_a[i], done_a[i]} !== 4'b1000) begin
                    n_bad++;
                    $display("FAIL reset_state inst%0d: got %b want 1000", i,
                             {line_a[i], busy_a[i], ready_a[i], done_a[i]});
                end
            end
        end
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            n_cmp++;
            if ({line_a[i], busy_a[i], ready_a[i], done_a[i]} !== 4'b1010) begin
                n_bad++;
                $display("FAIL reset_release inst%0d: got %b want 1010", i,
                         {line_a[i], busy_a[i], ready_a[i], done_a[i]});
            end
        end
    endtask

    task automatic test_frames(input int idx, input logic [7:0] first, input int nrand, input string name);
        logic [7:0] w;
        for (int f = 0; f <= nrand; f++) begin
            w = (f == 0) ? first : 8'($urandom_range(255, 0));
            exp_q.delete();
            add_frame(idx, w);
            add_idle(1);
            launch(idx, w);
            capture(idx, exp_q.size(), 8'($urandom_range(255, 0)), 1'b0, -5, 8'h00);
            foreach (exp_q[i]) begin
                n_cmp++;
                if (obs_q[i] !== exp_q[i]) begin
                    n_bad++;
                    $display("FAIL %s word %h cycle T0+%0d: got %b want %b", name, w, i + 1,
                             obs_q[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        exp_q.delete();
        add_frame(0, 8'h55);
        add_idle(1);
        add_frame(0, 8'hAA);
        add_idle(1);
        launch(0, 8'h55);
        capture(0, exp_q.size(), 8'hAA, 1'b1, -5, 8'h00);
        foreach (exp_q[i]) begin
            n_cmp++;
            if (obs_q[i] !== exp_q[i]) begin
                n_bad++;
                $display("FAIL back_to_back cycle T0+%0d: got %b want %b", i + 1, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_valid_while_busy();
        logic [7:0] w;
        int         f_len;
        int         pulses [2];
        f_len  = 10 * div_t[0];
        pulses = '{14, f_len - 1};
        foreach (pulses[p]) begin
            w = 8'($urandom_range(254, 0));
            exp_q.delete();
            add_frame(0, w);
            add_idle(8);
            launch(0, w);
            capture(0, exp_q.size(), w, 1'b0, pulses[p], 8'hFF);
            foreach (exp_q[i]) begin
                n_cmp++;
                if (obs_q[i] !== exp_q[i]) begin
                    n_bad++;
                    $display("FAIL valid_while_busy pulse@%0d cycle T0+%0d: got %b want %b",
                             pulses[p], i + 1, obs_q[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [3:0] v;
        launch(0, 8'h00);
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            if (i == 0) valid_a[0] = 1'b0;
        end
        // Cycle 18 is inside data bit 3; valid raised with reset must lose.
        rst_n        = 1'b0;
        valid_a[0]   = 1'b1;
        data_a[0]    = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            v = {line_a[0], busy_a[0], ready_a[0], done_a[0]};
            n_cmp++;
            if (v !== 4'b1000) begin
                n_bad++;
                $display("FAIL reset_mid_frame in_reset cycle %0d: got %b want 1000", i, v);
            end
        end
        rst_n      = 1'b1;
        valid_a[0] = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            v = {line_a[0], busy_a[0], ready_a[0], done_a[0]};
            n_cmp++;
            if (v !== 4'b1010) begin
                n_bad++;
                $display("FAIL reset_mid_frame after_release cycle %0d: got %b want 1010", i, v);
            end
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_frames(0, 8'hA5, 3, "single_8n1");
        test_frames(1, 8'h07, 2, "parity_odd");
        test_frames(2, 8'h07, 2, "parity_even");
        test_back_to_back();
        test_valid_while_busy();
        test_reset_mid_frame();
        test_frames(3, 8'h41, 1, "frame_7e2");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
